clk_div_prog: RTL
=================

Name: clk_div_prog

Overview:
- Parametrised, fully synchronous programmable clock divider; next generation of the fixed ripple ÷2^n dividers.
- One counter in the CLKIN domain generates:
  - a divided square wave (CLKOUT);
  - a one-cycle enable strobe (TICK) for logic that stays on CLKIN.
- Divisor is run-time reloadable through a request/ack handshake and applied only at a period boundary, so no runt pulses.
- Feeds the VGA/timer/sound blocks that currently each own a hard-wired divider.

Parameters:
- CNT_W, 16: counter and divisor width. Legal divisor range is 2..2^CNT_W-1.
- DIV_DEFAULT, 10000: divisor after reset (100 MHz -> 10 kHz). Elaboration error if <2 or >2^CNT_W-1.

Ports:
- CLKIN  in  1  system clock; all flops rise-edge except the optional-feature flop.
- ACLR  in  1  reset, asynchronous, active-high; clears all state.
- EN  in  1  count enable; when low, all state holds.
- DIV_IN  in  CNT_W  requested divisor D.
- DIV_LD  in  1  load request, level; held until DIV_ACK.
- DIV_ACK  out  1  one-cycle pulse: request consumed.
- DIV_ERR  out  1  one-cycle pulse coincident with DIV_ACK: request rejected (D<2).
- CLKOUT  out  1  divided clock, registered.
- TICK  out  1  one-cycle strobe, once per divided period.
- DIV_CUR  out  CNT_W  divisor currently in effect.

Behaviour:
- Reset values:
  - cnt=0, div_cur=DIV_DEFAULT, pending=0.
  - CLKOUT=0, TICK=0, DIV_ACK=0, DIV_ERR=0, DIV_CUR=DIV_DEFAULT.
- Counting (EN=1):
  - cnt advances 0..D-1, then wraps to 0.
  - The edge that wraps cnt to 0 is the "wrap edge". On it:
    - TICK goes to 1 for exactly one cycle;
    - CLKOUT goes to 1.
  - CLKOUT goes to 0 on the edge where cnt becomes floor(D/2).
  - Result: high for floor(D/2) cycles, low for ceil(D/2) cycles, period D.
  - D=2 gives 1 cycle high, 1 cycle low.
  - First wrap after reset occurs D enabled cycles after ACLR release.
- EN=0:
  - cnt, CLKOUT and pending hold; TICK forced to 0.
  - Counting resumes seamlessly on re-enable.
- Load handshake:
  - Request is sampled when DIV_LD=1 and pending=0.
  - If DIV_IN<2: DIV_ACK=DIV_ERR=1 on the next cycle; divisor unchanged.
  - Otherwise DIV_IN is captured into a shadow register and pending=1.
  - At the next wrap edge: div_cur<=shadow, pending<=0, and DIV_ACK pulses in the cycle after.
  - While pending=1, DIV_LD is ignored; no queueing.
  - Requester deasserts DIV_LD on the cycle DIV_ACK is seen. A DIV_LD still high in that cycle is a new request.
- Pending with EN=0:
  - Applied at the next edge.
  - cnt<=0 and CLKOUT<=0; the new period starts cleanly when EN rises.
- Simultaneous events:
  - Request captured on a wrap edge is not applied on that edge; it applies at the following wrap, after one full old-divisor period.
  - Wrap and DIV_ERR in the same cycle are independent.
- Mid-operation reset: pending request discarded and divisor returns to DIV_DEFAULT. No DIV_ACK is issued for the lost request; the requester must re-issue it.
- Latency:
  - Valid load: 1..D cycles from capture to application.
  - Reject: 1 cycle.

Optional Feature:
- Macro: CLKDIV_ODD50_EN.
- Defined:
  - Adds one negedge-CLKIN flop (cleared by ACLR) that samples the rise-domain CLKOUT.
  - For odd D, CLKOUT = rise_reg OR neg_reg, giving exactly D/2 cycles high (50% duty).
  - Even D and TICK timing are unchanged.
- Undefined: no negedge logic; odd-D duty is floor(D/2)/D as above.

Decomposition:
- Package clk_div_pkg holds:
  - CNT_W default;
  - DIV_MIN=2;
  - DIV_DEFAULT default;
  - function half_div(D) returning floor(D/2).
- One natural sub-module, clk_div_shadow: owns the shadow register, pending flag, validation, and DIV_ACK/DIV_ERR generation. Its interface is the wrap strobe and EN in, div_cur out.
- Counter and CLKOUT/TICK logic stay in the top.

Test Plan:
- Reset release, EN=1, D=DIV_DEFAULT=10000 -> first TICK at cycle 10000; CLKOUT high 5000 / low 5000; TICK period 10000.
- Load D=5 mid-period, DIV_LD held -> ack only after current period ends; afterwards CLKOUT 2 high / 3 low and TICK every 5 cycles. With CLKDIV_ODD50_EN: 2.5 high / 2.5 low.
- DIV_IN=1, then DIV_IN=0 -> DIV_ACK=DIV_ERR=1 one cycle later in each case; DIV_CUR unchanged; period unchanged.
- D=4, EN low for 7 cycles at cnt=1 -> CLKOUT frozen high, no TICK; on re-enable, next TICK exactly 3 enabled cycles later.
- Request D=3 accepted, then ACLR pulsed before the wrap -> DIV_CUR=DIV_DEFAULT, no DIV_ACK, outputs at reset values; counting restarts from 0.
- DIV_LD captured on a wrap edge with D=2 -> one more 2-cycle period at the old divisor, then the new divisor applies.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int CLKDIV_CNT_W       = 16;     // default counter / divisor width
  localparam int DIV_MIN            = 2;      // smallest divisor that makes a real period
  localparam int CLKDIV_DIV_DEFAULT = 10000;  // divisor after reset (100 MHz -> 10 kHz)

  // Count value at which the divided clock drops: floor(D/2).
  function automatic logic [31:0] half_div(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// clk_div_shadow: divisor reload path. Validates a load request, parks an
// accepted divisor in a shadow register and commits it at a period boundary
// (wrap edge, or immediately while counting is disabled).
//
// Handshake: DIV_LD is a level request sampled on any rising edge where no
// request is pending. DIV_ACK is a one-cycle pulse in the cycle after the
// request is consumed (rejected, or applied to div_cur); DIV_ERR pulses with
// it on rejection. The requester drops DIV_LD in the cycle it sees DIV_ACK; a
// DIV_LD still high at the end of that cycle is taken as a new request.
module clk_div_shadow
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DIV_DEFAULT = CLKDIV_DIV_DEFAULT
) (
  input  logic             CLKIN,
  input  logic             ACLR,
  input  logic             EN,
  input  logic             wrap,
  input  logic [CNT_W-1:0] DIV_IN,
  input  logic             DIV_LD,
  output logic             DIV_ACK,
  output logic             DIV_ERR,
  output logic             apply,
  output logic [CNT_W-1:0] div_cur
);

  logic [CNT_W-1:0] shadow;
  logic             pending;
  logic             req;
  logic             req_bad;

  assign req     = DIV_LD && !pending;
  assign req_bad = DIV_IN < CNT_W'(DIV_MIN);
  // Commit on the wrap edge, or on the next edge if counting is stopped.
  assign apply   = pending && (wrap || !EN);

  // Shadow/pending state and the registered ack/err pulses.
  always_ff @(posedge CLKIN or posedge ACLR) begin
    if (ACLR) begin
      div_cur <= CNT_W'(DIV_DEFAULT);
      shadow  <= '0;
      pending <= 1'b0;
      DIV_ACK <= 1'b0;
      DIV_ERR <= 1'b0;
    end else begin
      DIV_ACK <= 1'b0;
      DIV_ERR <= 1'b0;
      if (apply) begin
        div_cur <= shadow;
        pending <= 1'b0;
        DIV_ACK <= 1'b1;
      end else if (req) begin
        if (req_bad) begin
          DIV_ACK <= 1'b1;
          DIV_ERR <= 1'b1;
        end else begin
          shadow  <= DIV_IN;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable divider. One counter on CLKIN produces a divided
// square wave (CLKOUT, high floor(D/2) of every D cycles) and a one-cycle
// TICK enable on each wrap. The divisor is reloaded via clk_div_shadow.
// Optional macro CLKDIV_ODD50_EN adds a negedge flop that stretches the high
// phase by half a cycle for odd divisors, giving an exact 50% duty.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DIV_DEFAULT = CLKDIV_DIV_DEFAULT
) (
  input  logic             CLKIN,
  input  logic             ACLR,
  input  logic             EN,
  input  logic [CNT_W-1:0] DIV_IN,
  input  logic             DIV_LD,
  output logic             DIV_ACK,
  output logic             DIV_ERR,
  output logic             CLKOUT,
  output logic             TICK,
  output logic [CNT_W-1:0] DIV_CUR
);

  generate
    if (DIV_DEFAULT < DIV_MIN ||
        longint'(DIV_DEFAULT) > ((longint'(1) << CNT_W) - longint'(1))) begin : g_bad_default
      $error("clk_div_prog: DIV_DEFAULT outside 2..2^CNT_W-1");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] half;
  logic             wrap;
  logic             apply;
  logic             clk_rise;
  logic             tick_r;

  assign cnt_nxt = cnt + CNT_W'(1);
  assign half    = CNT_W'(half_div(32'(div_cur)));
  assign wrap    = EN && (cnt == div_cur - CNT_W'(1));
  assign TICK    = tick_r;
  assign DIV_CUR = div_cur;

  clk_div_shadow #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_shadow (
    .CLKIN   (CLKIN),
    .ACLR    (ACLR),
    .EN      (EN),
    .wrap    (wrap),
    .DIV_IN  (DIV_IN),
    .DIV_LD  (DIV_LD),
    .DIV_ACK (DIV_ACK),
    .DIV_ERR (DIV_ERR),
    .apply   (apply),
    .div_cur (div_cur)
  );

  // Period counter, divided clock and wrap strobe; a divisor committed while
  // stopped restarts the period from zero with the clock low.
  always_ff @(posedge CLKIN or posedge ACLR) begin
    if (ACLR) begin
      cnt      <= '0;
      clk_rise <= 1'b0;
      tick_r   <= 1'b0;
    end else if (!EN) begin
      tick_r <= 1'b0;
      if (apply) begin
        cnt      <= '0;
        clk_rise <= 1'b0;
      end
    end else if (wrap) begin
      cnt      <= '0;
      clk_rise <= 1'b1;
      tick_r   <= 1'b1;
    end else begin
      cnt    <= cnt_nxt;
      tick_r <= 1'b0;
      if (cnt_nxt == half) clk_rise <= 1'b0;
    end
  end

`ifdef CLKDIV_ODD50_EN
  logic clk_neg;

  // Half-cycle-delayed copy of the divided clock, used to stretch odd highs.
  always_ff @(negedge CLKIN or posedge ACLR) begin
    if (ACLR) clk_neg <= 1'b0;
    else      clk_neg <= clk_rise;
  end

  assign CLKOUT = div_cur[0] ? (clk_rise | clk_neg) : clk_rise;
`else
  assign CLKOUT = clk_rise;
`endif

endmodule
